// File: rtl/traffic_phase_controller_pkg.sv
// traffic_pkg: state codes, lamp encodings and direction constants
// shared by the intersection phase sequencer.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_NS_G  = 3'd0,
        S_NS_Y  = 3'd1,
        S_RED1  = 3'd2,
        S_EW_G  = 3'd3,
        S_EW_Y  = 3'd4,
        S_RED2  = 3'd5,
        S_WALK  = 3'd6,
        S_FLASH = 3'd7
    } state_t;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_t;

    localparam logic [2:0] LIGHT_R   = 3'b100;
    localparam logic [2:0] LIGHT_Y   = 3'b010;
    localparam logic [2:0] LIGHT_G   = 3'b001;
    localparam logic [2:0] LIGHT_OFF = 3'b000;

    // {ns, ew} lamp pattern shown while in state s
    function automatic logic [5:0] head_lights(state_t s, logic blink);
        logic [5:0] r;
        r = {LIGHT_R, LIGHT_R};
        case (s)
            S_NS_G:  r = {LIGHT_G, LIGHT_R};
            S_NS_Y:  r = {LIGHT_Y, LIGHT_R};
            S_EW_G:  r = {LIGHT_R, LIGHT_G};
            S_EW_Y:  r = {LIGHT_R, LIGHT_Y};
            S_FLASH: r = blink ? {LIGHT_Y, LIGHT_R}
                               : {LIGHT_OFF, LIGHT_OFF};
            default: r = {LIGHT_R, LIGHT_R};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/traffic_phase_controller_if.sv
// Request inputs and lamp/status outputs of the phase sequencer.
// master drives requests; slave is the controller.
interface traffic_phase_controller_if;

    logic       ped_req;
    logic       flash_mode;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_pending;
    logic [2:0] state_dbg;
    logic [7:0] secs_left;

    modport master (
        output ped_req, flash_mode,
        input  ns_light, ew_light, walk,
        input  ped_pending, state_dbg, secs_left
    );

    modport slave (
        input  ped_req, flash_mode,
        output ns_light, ew_light, walk,
        output ped_pending, state_dbg, secs_left
    );

endinterface

// File: rtl/traffic_phase_controller_tick_prescaler.sv
// tick_prescaler: 1-cycle tick every TICK_DIV clocks;
// clear restarts the count at a phase boundary.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// Intersection phase sequencer with night flash; the pedestrian
// phase and green cut exist only when PED_PHASE_EN is defined.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int GREEN_S     = 10,
    parameter int YELLOW_S    = 3,
    parameter int ALLRED_S    = 1,
    parameter int WALK_S      = 8,
    parameter int MIN_GREEN_S = 4
) (
    input  logic clk,
    input  logic reset_n,
    traffic_phase_controller_if.slave bus
);

    localparam logic [7:0] GRN = 8'(GREEN_S);
    localparam logic [7:0] YEL = 8'(YELLOW_S);
    localparam logic [7:0] RED = 8'(ALLRED_S);
    localparam logic [7:0] WLK = 8'(WALK_S);

    state_t     state, nxt;
    dir_t       dir, nxt_dir;
    logic [7:0] secs, nxt_secs;
    logic       blink, nxt_blink;
    logic       pend, nxt_pend;
    logic [2:0] ns_q, ew_q;
    logic       walk_q;
    logic       tick, phase_end;
    logic       cut, ped_go;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (phase_end),
        .tick    (tick)
    );

`ifdef PED_PHASE_EN
    // elapsed green seconds including the current one
    assign cut    = pend &&
                    (GREEN_S - int'(secs) + 1 >= MIN_GREEN_S);
    assign ped_go = pend;

    always_comb begin
        nxt_pend = pend;
        if (bus.ped_req && state != S_WALK && state != S_FLASH)
            nxt_pend = 1'b1;
        if (phase_end && (nxt == S_WALK || nxt == S_FLASH))
            nxt_pend = 1'b0;
    end
`else
    logic unused_ped_req;
    assign unused_ped_req = bus.ped_req;
    assign cut            = 1'b0;
    assign ped_go         = 1'b0;
    assign nxt_pend       = 1'b0;
`endif

    always_comb begin
        nxt       = state;
        nxt_secs  = secs;
        nxt_dir   = dir;
        nxt_blink = blink;
        phase_end = 1'b0;
        if (tick) begin
            unique case (state)
                S_NS_G, S_EW_G: begin
                    if (secs == 8'd1 || cut) begin
                        phase_end = 1'b1;
                        nxt = (state == S_NS_G) ? S_NS_Y : S_EW_Y;
                        nxt_secs = YEL;
                    end
                end
                S_NS_Y, S_EW_Y: begin
                    if (secs == 8'd1) begin
                        phase_end = 1'b1;
                        nxt = (state == S_NS_Y) ? S_RED1 : S_RED2;
                        nxt_dir = (state == S_NS_Y) ? DIR_EW : DIR_NS;
                        nxt_secs = RED;
                    end
                end
                S_RED1, S_RED2: begin
                    if (secs == 8'd1) begin
                        phase_end = 1'b1;
                        if (bus.flash_mode) begin
                            nxt = S_FLASH;
                            nxt_secs = 8'd0;
                            nxt_blink = 1'b1;
                        end else if (ped_go) begin
                            nxt = S_WALK;
                            nxt_secs = WLK;
                        end else begin
                            nxt = (dir == DIR_NS) ? S_NS_G : S_EW_G;
                            nxt_secs = GRN;
                        end
                    end
                end
                S_WALK: begin
                    if (secs == 8'd1) begin
                        phase_end = 1'b1;
                        nxt = (dir == DIR_NS) ? S_NS_G : S_EW_G;
                        nxt_secs = GRN;
                    end
                end
                S_FLASH: begin
                    if (!bus.flash_mode) begin
                        phase_end = 1'b1;
                        nxt = S_RED2;
                        nxt_secs = RED;
                        nxt_dir = DIR_NS;
                    end else begin
                        nxt_blink = ~blink;
                    end
                end
            endcase
            // flash holds secs_left at 0
            if (!phase_end && state != S_FLASH)
                nxt_secs = secs - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_RED2;
            secs   <= RED;
            dir    <= DIR_NS;
            blink  <= 1'b0;
            pend   <= 1'b0;
            ns_q   <= LIGHT_R;
            ew_q   <= LIGHT_R;
            walk_q <= 1'b0;
        end else begin
            state        <= nxt;
            secs         <= nxt_secs;
            dir          <= nxt_dir;
            blink        <= nxt_blink;
            pend         <= nxt_pend;
            {ns_q, ew_q} <= head_lights(nxt, nxt_blink);
            walk_q       <= (nxt == S_WALK);
        end
    end

    assign bus.ns_light    = ns_q;
    assign bus.ew_light    = ew_q;
    assign bus.walk        = walk_q;
    assign bus.ped_pending = pend;
    assign bus.state_dbg   = state;
    assign bus.secs_left   = secs;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: phase table, directed
// ped/flash/reset sequences and a random run against a model.
module tb_traffic_phase_controller;

    localparam int TD = 4;
    localparam int GS = 5;
    localparam int YS = 2;
    localparam int AS = 1;
    localparam int WS = 3;
    localparam int MG = 2;
`ifdef PED_PHASE_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    traffic_phase_controller_if bus();

    traffic_phase_controller #(
        .TICK_DIV    (TD),
        .GREEN_S     (GS),
        .YELLOW_S    (YS),
        .ALLRED_S    (AS),
        .WALK_S      (WS),
        .MIN_GREEN_S (MG)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: phase code, cycles spent in phase, phase seconds
    int m_ph, m_el, m_dur;
    bit m_pend, m_dir;

    function automatic int dur_of(int ph);
        case (ph)
            0, 3:    return GS;
            1, 4:    return YS;
            2, 5:    return AS;
            6:       return WS;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = 5; m_el = 0; m_dur = AS;
        m_pend = 1'b0; m_dir = 1'b0;
    endtask

    task automatic model_step(bit req, bit fm);
        int k, nx;
        bit tk, np;
        tk = (m_el % TD) == TD - 1;
        k  = m_el / TD + 1;
        nx = -1;
        np = m_pend | (PED && req && m_ph != 6 && m_ph != 7);
        if (tk) begin
            case (m_ph)
                0, 3: if (k == m_dur || (PED && m_pend && k >= MG))
                          nx = m_ph + 1;
                1: if (k == m_dur) begin nx = 2; m_dir = 1'b1; end
                4: if (k == m_dur) begin nx = 5; m_dir = 1'b0; end
                2, 5: if (k == m_dur)
                          nx = fm ? 7 : (PED && m_pend) ? 6
                             : (m_dir ? 3 : 0);
                6: if (k == m_dur) nx = m_dir ? 3 : 0;
                7: if (!fm) begin nx = 5; m_dir = 1'b0; end
                default: ;
            endcase
        end
        if (nx >= 0) begin
            if (nx == 6 || nx == 7) np = 1'b0;
            m_ph = nx; m_el = 0; m_dur = dur_of(nx);
        end else begin
            m_el++;
        end
        m_pend = np;
    endtask

    function automatic logic [18:0] model_out();
        logic [2:0] ns, ew;
        logic [7:0] s;
        bit bl;
        ns = 3'b100; ew = 3'b100;
        bl = ((m_el / TD) % 2) == 0;
        case (m_ph)
            0: ns = 3'b001;
            1: ns = 3'b010;
            3: ew = 3'b001;
            4: ew = 3'b010;
            7: begin
                ns = bl ? 3'b010 : 3'b000;
                ew = bl ? 3'b100 : 3'b000;
            end
            default: ;
        endcase
        s = (m_ph == 7) ? 8'd0 : 8'(m_dur - m_el / TD);
        return {3'(m_ph), s, ns, ew, m_ph == 6, m_pend};
    endfunction

    function automatic logic [18:0] dut_out();
        return {bus.state_dbg, bus.secs_left, bus.ns_light,
                bus.ew_light, bus.walk, bus.ped_pending};
    endfunction

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cyc(bit req, bit fm);
        bus.ped_req = req;
        bus.flash_mode = fm;
        check("model", 32'(dut_out()), 32'(model_out()));
        @(posedge clk);
        model_step(req, fm);
        #1;
        bus.ped_req = 1'b0;
    endtask

    typedef struct {
        int         st;
        int         cycles;
        logic [2:0] ns;
        logic [2:0] ew;
        int         s0;
    } ph_rec_t;

    ph_rec_t tbl[8];

    initial begin
        bit fm;
        tbl[0] = '{5, 4,  3'b100, 3'b100, AS};
        tbl[1] = '{0, 20, 3'b001, 3'b100, GS};
        tbl[2] = '{1, 8,  3'b010, 3'b100, YS};
        tbl[3] = '{2, 4,  3'b100, 3'b100, AS};
        tbl[4] = '{3, 20, 3'b100, 3'b001, GS};
        tbl[5] = '{4, 8,  3'b100, 3'b010, YS};
        tbl[6] = '{5, 4,  3'b100, 3'b100, AS};
        tbl[7] = '{0, 1,  3'b001, 3'b100, GS};

        bus.ped_req = 1'b0;
        bus.flash_mode = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_vals",
              {bus.state_dbg, bus.secs_left, bus.ns_light,
               bus.ew_light, bus.walk, bus.ped_pending},
              {3'd5, 8'd1, 3'b100, 3'b100, 1'b0, 1'b0});
        reset_n = 1'b1;

        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < tbl[r].cycles; c++) begin
                check($sformatf("tbl%0d_c%0d", r, c),
                      {bus.state_dbg, bus.secs_left,
                       bus.ns_light, bus.ew_light},
                      {3'(tbl[r].st), 8'(tbl[r].s0 - c / TD),
                       tbl[r].ns, tbl[r].ew});
                cyc(1'b0, 1'b0);
            end
        end

        // ped press on cycle 1 of NS_G, repeat press while pending
        cyc(1'b1, 1'b0);
        check("ped_set", bus.ped_pending, PED);
        cyc(1'b1, 1'b0);
        repeat (5) cyc(1'b0, 1'b0);
        check("cut_state", bus.state_dbg, PED ? 1 : 0);
        repeat (12) cyc(1'b0, 1'b0);
        check("walk_state", {bus.state_dbg, bus.secs_left},
              PED ? {3'd6, 8'd3} : {3'd1, 8'd2});
        check("walk_lamp",
              {bus.walk, bus.ns_light, bus.ew_light, bus.ped_pending},
              PED ? {1'b1, 3'b100, 3'b100, 1'b0}
                  : {1'b0, 3'b010, 3'b100, 1'b0});
        cyc(1'b1, 1'b0);
        repeat (11) cyc(1'b0, 1'b0);
        check("post_walk", {bus.state_dbg, bus.ped_pending},
              {3'd3, 1'b0});

        // flash requested mid EW_G waits for all-red
        repeat (10) cyc(1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b1);
        check("flash_defer_y", bus.state_dbg, 4);
        repeat (8) cyc(1'b0, 1'b1);
        check("flash_defer_r", bus.state_dbg, 5);
        repeat (4) cyc(1'b0, 1'b1);
        check("flash_on",
              {bus.state_dbg, bus.secs_left, bus.ns_light, bus.ew_light},
              {3'd7, 8'd0, 3'b010, 3'b100});
        repeat (4) cyc(1'b0, 1'b1);
        check("flash_dark", {bus.ns_light, bus.ew_light}, 0);
        repeat (4) cyc(1'b0, 1'b1);
        check("flash_lit", bus.ns_light, 3'b010);
        repeat (4) cyc(1'b0, 1'b0);
        check("flash_exit",
              {bus.state_dbg, bus.secs_left, bus.ns_light, bus.ew_light},
              {3'd5, 8'd1, 3'b100, 3'b100});
        repeat (4) cyc(1'b0, 1'b0);
        check("flash_ns_g", {bus.state_dbg, bus.secs_left},
              {3'd0, 8'd5});

        // async reset in the middle of EW_Y
        repeat (52) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check("pre_rst", {bus.state_dbg, bus.ped_pending}, {3'd4, PED});
        #2 reset_n = 1'b0;
        #1;
        check("async_rst",
              {bus.state_dbg, bus.secs_left, bus.ns_light,
               bus.ew_light, bus.walk, bus.ped_pending},
              {3'd5, 8'd1, 3'b100, 3'b100, 1'b0, 1'b0});
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        fm = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) fm = ~fm;
            cyc($urandom_range(0, 15) == 0, fm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

endmodule
